// File: rtl/pulse_counter_pkg.sv
// ---------------------------------------------------------------------------
// pulse_counter_pkg
//   Shared constants and helpers for the pulse counter datapath.
//   - BCD_W      : width of one packed BCD digit
//   - BCD_MAX    : largest legal digit value; a digit never holds 10..15
//   - DIGITS_MAX : largest supported number of digits in pulse_counter
// ---------------------------------------------------------------------------
package pulse_counter_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam int DIGITS_MAX = 8;

  // True when a digit is at its top value and will wrap on the next carry-in.
  function automatic logic bcd_is_max(input logic [BCD_W-1:0] d);
    return (d == BCD_MAX);
  endfunction

  // Next value of a digit that receives a carry-in: 9 wraps back to 0.
  function automatic logic [BCD_W-1:0] bcd_next(input logic [BCD_W-1:0] d);
    return bcd_is_max(d) ? '0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// ---------------------------------------------------------------------------
// bcd_digit
//   One decimal digit of the ripple-carry BCD counter.
//
//   Ports:
//     clock  in   system clock, rising-edge active
//     reset  in   asynchronous active-high reset (digit -> 0)
//     clear  in   synchronous clear (digit -> 0), wins over cin
//     cin    in   carry-in: advance this digit on the next edge
//     digit  out  registered digit value, always 0..9
//     cout   out  carry-out: cin while the digit is 9 (it wraps to 0)
//
//   cout is combinational from cin and the registered digit so that a whole
//   chain of digits ripples within one cycle; it feeds only the next digit
//   or a register in the parent, never a module output directly.
// ---------------------------------------------------------------------------
module bcd_digit
  import pulse_counter_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             cin,
  output logic [BCD_W-1:0] digit,
  output logic             cout
);

  assign cout = cin & bcd_is_max(digit);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      digit <= '0;
    end else if (clear) begin
      digit <= '0;
    end else if (cin) begin
      digit <= bcd_next(digit);
    end
  end

endmodule

// File: rtl/pulse_counter.sv
// ---------------------------------------------------------------------------
// pulse_counter
//   Counts accepted edges of the debounced level `clean` in a packed BCD
//   counter of DIGITS digits for display.
//
//   Parameters:
//     DIGITS    number of BCD digits, 1..8; count is 4*DIGITS bits wide
//
//   Ports:
//     clock     in   system clock, rising-edge active
//     reset     in   asynchronous active-high reset
//     clean     in   debounced level, already synchronous to clock
//     enable    in   1 = accept edges, 0 = ignore them (tracking continues)
//     clear     in   synchronous clear of count and overflow
//     count     out  packed BCD value, digit 0 in [3:0]
//     tick      out  one-cycle strobe per accepted increment
//     overflow  out  sticky flag, set when the count wraps all-9s -> 0
//
//   Build option:
//     PULSE_COUNTER_BOTH_EDGES_EN  when defined, both rising and falling
//                                  edges of clean count; otherwise only
//                                  rising edges count.
//
//   Every output comes straight from a flop, so there is no combinational
//   path from any input to any output.
// ---------------------------------------------------------------------------
module pulse_counter
  import pulse_counter_pkg::*;
#(
  parameter int DIGITS = 4
)(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clean,
  input  logic                  enable,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick,
  output logic                  overflow
);

  if (DIGITS < 1 || DIGITS > DIGITS_MAX) begin : g_digits_range
    $error("pulse_counter: DIGITS must be in 1..%0d", DIGITS_MAX);
  end

  logic              clean_q;
  logic              edge_det;
  logic              inc;
  logic [DIGITS:0]   carry;

  // clean_q resets to 1 so a level already high when reset is released is
  // treated as "seen" and does not produce a count.
`ifdef PULSE_COUNTER_BOTH_EDGES_EN
  assign edge_det = clean ^ clean_q;
`else
  assign edge_det = clean & ~clean_q;
`endif

  // clear has priority: an edge that coincides with clear is dropped, and
  // since clean_q still tracks clean it is not replayed afterwards.
  assign inc      = edge_det & enable & ~clear;
  assign carry[0] = inc;

  // Ripple-carry chain: digit gi advances when inc is set and all lower
  // digits are 9.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    bcd_digit u_digit (
      .clock (clock),
      .reset (reset),
      .clear (clear),
      .cin   (carry[gi]),
      .digit (count[gi*BCD_W +: BCD_W]),
      .cout  (carry[gi+1])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clean_q  <= 1'b1;
      tick     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      clean_q <= clean;
      tick    <= inc;
      if (clear) begin
        overflow <= 1'b0;
      end else if (carry[DIGITS]) begin
        // Carry out of the top digit means the whole count wrapped to 0.
        overflow <= 1'b1;
      end
    end
  end

endmodule
